// File: rtl/midi_note_pitch_rx.sv
// Monophonic MIDI channel-voice decoder for one channel. It tracks note, velocity, gate and
// the 14-bit pitch wheel, and writes each pitch-bend value in a single update.
module midi_note_pitch_rx #(
  parameter int unsigned CHANNEL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_rdy,
  input  logic [7:0]  byte_data,
  output logic [6:0]  note,
  output logic [6:0]  velocity,
  output logic        gate,
  output logic [13:0] pitch,
  output logic        upd
);

  localparam logic [3:0] ChanNib = 4'(CHANNEL);

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [6:0]  d1_q, d1_d;
  logic [6:0]  note_q, note_d;
  logic [6:0]  vel_q, vel_d;
  logic        gate_q, gate_d;
  logic [13:0] pitch_q, pitch_d;
  logic        upd_q, upd_d;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    d1_d    = d1_q;
    note_d  = note_q;
    vel_d   = vel_q;
    gate_d  = gate_q;
    pitch_d = pitch_q;
    upd_d   = 1'b0;
    if (byte_rdy) begin
      if (byte_data[7]) begin
        if (byte_data[7:3] == 5'b11111) begin
          // Realtime bytes are transparent to message parsing.
          state_d = state_q;
        end else if (byte_data[7:4] == 4'hF) begin
          state_d = StIdle;
        end else if (byte_data[3:0] == ChanNib) begin
          cmd_d   = byte_data[7:4];
          state_d = StWaitD1;
        end else begin
          state_d = StIdle;
        end
      end else begin
        unique case (state_q)
          StWaitD1: begin
            d1_d    = byte_data[6:0];
            state_d = (cmd_q == 4'hC || cmd_q == 4'hD) ? StWaitD1 : StWaitD2;
          end
          StWaitD2: begin
            state_d = StWaitD1;
            if (cmd_q == 4'h9 && byte_data[6:0] != 7'd0) begin
              note_d = d1_q;
              vel_d  = byte_data[6:0];
              gate_d = 1'b1;
              upd_d  = 1'b1;
            end else if (cmd_q == 4'h9 || cmd_q == 4'h8) begin
              // Note-off only releases the note currently sounding.
              if (gate_q && d1_q == note_q) begin
                gate_d = 1'b0;
                upd_d  = 1'b1;
              end
            end else if (cmd_q == 4'hE) begin
              pitch_d = {byte_data[6:0], d1_q};
              upd_d   = 1'b1;
            end else if (cmd_q == 4'hB && (d1_q == 7'd123 || d1_q == 7'd120)) begin
              gate_d = 1'b0;
              upd_d  = 1'b1;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cmd_q   <= 4'h0;
      d1_q    <= 7'd0;
      note_q  <= 7'd0;
      vel_q   <= 7'd0;
      gate_q  <= 1'b0;
      pitch_q <= 14'd8192;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      d1_q    <= d1_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      gate_q  <= gate_d;
      pitch_q <= pitch_d;
      upd_q   <= upd_d;
    end
  end

  assign note     = note_q;
  assign velocity = vel_q;
  assign gate     = gate_q;
  assign pitch    = pitch_q;
  assign upd      = upd_q;

endmodule

// File: tb/tb_midi_note_pitch_rx.sv
// Randomised bench for midi_note_pitch_rx: a message-level reference model, directed cases
// and a random byte stream.
module tb_midi_note_pitch_rx;

  localparam int Chan = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_rdy;
  logic [7:0]  byte_data;
  logic [6:0]  note;
  logic [6:0]  velocity;
  logic        gate;
  logic [13:0] pitch;
  logic        upd;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_note, m_vel, m_gate, m_pitch, m_upd;
  int rs;
  int pend[$];

  always #5 clk = ~clk;

  midi_note_pitch_rx #(.CHANNEL(Chan)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_rdy  (byte_rdy),
    .byte_data (byte_data),
    .note      (note),
    .velocity  (velocity),
    .gate      (gate),
    .pitch     (pitch),
    .upd       (upd)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_note = 0; m_vel = 0; m_gate = 0; m_pitch = 8192; m_upd = 0;
    rs = -1;
    pend.delete();
  endtask

  task automatic model_note_off(input int d1);
    if (m_gate == 1 && d1 == m_note) begin
      m_gate = 0;
      m_upd  = 1;
    end
  endtask

  // Collects data bytes after a status until the message length is reached, then acts on it.
  task automatic model_byte(input int b);
    int need, d1, v;
    m_upd = 0;
    if (b >= 248) return;
    if (b >= 128) begin
      rs = (b < 240 && (b % 16) == Chan) ? b / 16 : -1;
      pend.delete();
      return;
    end
    if (rs < 0) return;
    pend.push_back(b);
    need = (rs == 12 || rs == 13) ? 1 : 2;
    if (pend.size() < need) return;
    d1 = pend[0];
    v  = pend[need-1];
    pend.delete();
    case (rs)
      9: begin
        if (v > 0) begin
          m_note = d1; m_vel = v; m_gate = 1; m_upd = 1;
        end else model_note_off(d1);
      end
      8:  model_note_off(d1);
      14: begin m_pitch = v * 128 + d1; m_upd = 1; end
      11: if (d1 == 123 || d1 == 120) begin m_gate = 0; m_upd = 1; end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("note", int'(note), m_note);
    check("velocity", int'(velocity), m_vel);
    check("gate", int'(gate), m_gate);
    check("pitch", int'(pitch), m_pitch);
    check("upd", int'(upd), m_upd);
  endtask

  task automatic send(input int b);
    @(negedge clk);
    byte_rdy  = 1'b1;
    byte_data = 8'(b);
    model_byte(b);
    @(posedge clk);
    #1;
    byte_rdy = 1'b0;
    compare_all();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    byte_rdy  = 1'b0;
    byte_data = 8'($urandom_range(0, 255));
    m_upd = 0;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int rand_byte();
    int r, cmds[7];
    cmds = '{8, 9, 10, 11, 12, 13, 14};
    r = $urandom_range(0, 9);
    if (r == 0) return 248 + $urandom_range(0, 7);
    if (r == 1) return 240 + $urandom_range(0, 7);
    if (r <= 3) return cmds[$urandom_range(0, 6)] * 16 + (($urandom_range(0, 3) == 0) ? 1 : 0);
    case ($urandom_range(0, 5))
      0: return 60 + $urandom_range(0, 3);
      1: return 0;
      2: return 123;
      3: return 120;
      default: return $urandom_range(0, 127);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    byte_rdy = 1'b0;
    byte_data = 8'h00;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Basic note-on, upd drops the cycle after
    send(8'h90); send(8'h3C); send(8'h64);
    check("dir_note60", int'(note), 60);
    check("dir_vel100", int'(velocity), 100);
    check("dir_upd_pulse", int'(upd), 1);
    idle_cycle();

    // Running status with note-off matching
    send(8'h40); send(8'h50); send(8'h3C); send(8'h00);
    check("dir_gate_held", int'(gate), 1);
    send(8'h40); send(8'h00);
    check("dir_gate_off", int'(gate), 0);
    check("dir_note64", int'(note), 64);

    // Pitch bend, with realtime and an aborting status in the middle
    send(8'hE0); send(8'h00); send(8'h7F);
    check("dir_pitch", int'(pitch), 16256);
    send(8'hE0); send(8'h10); send(8'hFE); send(8'h20);
    check("dir_pitch_rt", int'(pitch), 32 * 128 + 16);
    send(8'hE0); send(8'h00); send(8'hB0); send(8'h7F);
    check("dir_pitch_abort", int'(pitch), 32 * 128 + 16);

    // Channel filter and one-byte messages
    send(8'h91); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
    send(8'hC0); send(8'h05); send(8'h90); send(8'h30); send(8'h10);
    check("dir_note48", int'(note), 48);

    // All notes off, then sysex
    send(8'hB0); send(8'h7B); send(8'h00);
    check("dir_cc_gate", int'(gate), 0);
    send(8'hF0); send(8'h12); send(8'h34); send(8'hF7); send(8'h3C); send(8'h64);

    // Reset mid-message
    send(8'hE0); send(8'h10);
    do_reset();
    check("dir_rst_pitch", int'(pitch), 8192);
    send(8'h20);

    // Random stream
    for (int i = 0; i < 1500; i++) begin
      send(rand_byte());
      if ($urandom_range(0, 7) == 0) idle_cycle();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
